diram_phy_responder: RTL and testbench

//  Far-end DiRAM port responder for the manager DFI command/data stream. Sits on the PHY side of dfi.

---
 rtl/diram_phy_responder_pkg.sv | 21 ++
 rtl/diram_burst_ctrl.sv | 96 +++++++++
 rtl/diram_phy_responder.sv | 138 +++++++++++++
 tb/tb_diram_phy_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/diram_phy_responder_pkg.sv
// Shared definitions for the DiRAM PHY-side responder: DFI command encodings,
// default burst/latency values and a beat-counter width helper.
package diram_phy_responder_pkg;

  typedef enum logic [1:0] {
    DIRAM_CMD_PO = 2'b00,
    DIRAM_CMD_PC = 2'b01,
    DIRAM_CMD_CR = 2'b10,
    DIRAM_CMD_CW = 2'b11
  } diram_cmd_e;

  localparam int DIRAM_BURST  = 2;
  localparam int DIRAM_RD_LAT = 4;
  localparam int DIRAM_WR_LAT = 1;

  // Beat counters never shrink below one bit so single-beat bursts still elaborate.
  function automatic int beat_w(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/diram_burst_ctrl.sv
// One data-bus burst engine: occupancy check, {start,index} latency shift register
// and a wrapping beat counter. Used once for the read bus and once for the write bus.
module diram_burst_ctrl
  import diram_phy_responder_pkg::*;
#(
  parameter  int LAT   = 1,
  parameter  int BURST = 2,
  parameter  int IDX_W = 8,
  localparam int CNT_W = beat_w(BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [IDX_W-1:0] req_idx,
  output logic             overlap,
  output logic             beat_act,
  output logic [IDX_W-1:0] beat_idx,
  output logic [CNT_W-1:0] beat_num
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  logic [CNT_W-1:0] busy_reg;
  logic             busy;
  logic             accept;
  logic             s_out;
  logic [IDX_W-1:0] i_out;
  logic             active_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;

  // Every burst shares the same latency, so two bursts collide exactly when
  // their commands are fewer than BURST cycles apart.
  assign busy    = (busy_reg != '0);
  assign accept  = req && !busy;
  assign overlap = req && busy;

  always_ff @(posedge clk) begin
    if (!rst_n)       busy_reg <= '0;
    else if (accept)  busy_reg <= LAST;
    else if (busy)    busy_reg <= busy_reg - CNT_W'(1);
  end

  generate
    if (LAT == 0) begin : g_direct
      assign s_out = accept;
      assign i_out = req_idx;
    end else begin : g_pipe
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic             start_reg;
        logic [IDX_W-1:0] idx_sr_reg;
        logic             start_in;
        logic [IDX_W-1:0] idx_in;
        if (gi == 0) begin : g_head
          assign start_in = accept;
          assign idx_in   = req_idx;
        end else begin : g_tail
          assign start_in = g_stage[gi-1].start_reg;
          assign idx_in   = g_stage[gi-1].idx_sr_reg;
        end
        always_ff @(posedge clk) begin
          if (!rst_n) start_reg <= 1'b0;
          else        start_reg <= start_in;
          idx_sr_reg <= idx_in;
        end
      end
      assign s_out = g_stage[LAT-1].start_reg;
      assign i_out = g_stage[LAT-1].idx_sr_reg;
    end
  endgenerate

  // Beat 0 is served straight off the pipeline tail; the counter covers beats 1..BURST-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
    end else if (s_out) begin
      active_reg <= (BURST > 1);
      cnt_reg    <= (BURST > 1) ? CNT_W'(1) : '0;
      idx_reg    <= i_out;
    end else if (active_reg) begin
      if (cnt_reg == LAST) begin
        active_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign beat_act = s_out || active_reg;
  assign beat_idx = s_out ? i_out : idx_reg;
  assign beat_num = s_out ? '0 : cnt_reg;

endmodule

// File: rtl/diram_phy_responder.sv
// Far-end DiRAM port responder: decodes DFI commands, tracks open banks,
// stores write bursts and returns read bursts after a fixed latency.
module diram_phy_responder
  import diram_phy_responder_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int BANK_W = 5,
  parameter int ADDR_W = 10,
  parameter int BURST  = DIRAM_BURST,
  parameter int RD_LAT = DIRAM_RD_LAT,
  parameter int WR_LAT = DIRAM_WR_LAT,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  input  logic              dfi__phy__cs,
  input  logic              dfi__phy__cmd1,
  input  logic              dfi__phy__cmd0,
  input  logic [BANK_W-1:0] dfi__phy__bank,
  input  logic [ADDR_W-1:0] dfi__phy__addr,
  input  logic [DATA_W-1:0] dfi__phy__data,
  output logic              phy__dfi__valid,
  output logic [DATA_W-1:0] phy__dfi__data,
  output logic              phy__err_closed,
  output logic              phy__err_overlap
);

  localparam int CNT_W   = beat_w(BURST);
  localparam int NBANK   = 2 ** BANK_W;
  localparam int LINE_AW = MEM_AW + CNT_W;

  diram_cmd_e        cmd;
  logic [NBANK-1:0]  open_vec;
  logic              bank_open;
  logic              is_po, is_pc, is_cr, is_cw;
  logic [MEM_AW-1:0] cmd_idx;
  logic              rd_overlap, wr_overlap;
  logic              rd_act, wr_act, wr_en;
  logic [MEM_AW-1:0] rd_idx, wr_idx;
  logic [CNT_W-1:0]  rd_beat, wr_beat;
  logic [LINE_AW-1:0] rd_addr, wr_addr;
  logic              err_closed_reg, err_overlap_reg;
  logic [ADDR_W-1:0] page_mem [NBANK];
  logic [DATA_W-1:0] mem [2**LINE_AW];
  logic [DATA_W-1:0] rd_mem_reg, hold_reg;
  logic              rd_valid_reg;
  logic [LINE_AW-1:0] rd_addr_reg;
  logic              byp;

  assign cmd       = diram_cmd_e'({dfi__phy__cmd1, dfi__phy__cmd0});
  assign bank_open = open_vec[dfi__phy__bank];
  assign is_po     = dfi__phy__cs && (cmd == DIRAM_CMD_PO);
  assign is_pc     = dfi__phy__cs && (cmd == DIRAM_CMD_PC);
  assign is_cr     = dfi__phy__cs && (cmd == DIRAM_CMD_CR);
  assign is_cw     = dfi__phy__cs && (cmd == DIRAM_CMD_CW);
  assign cmd_idx   = MEM_AW'({dfi__phy__bank, dfi__phy__addr});

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    logic open_reg;
    always_ff @(posedge clk) begin
      if (!reset_poweron_n) begin
        open_reg <= 1'b0;
      end else if (dfi__phy__bank == BANK_W'(gi)) begin
        if (is_po)      open_reg <= 1'b1;
        else if (is_pc) open_reg <= 1'b0;
      end
    end
    assign open_vec[gi] = open_reg;
  end

  always_ff @(posedge clk) begin
    if (is_po) page_mem[dfi__phy__bank] <= dfi__phy__addr;
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      err_closed_reg  <= 1'b0;
      err_overlap_reg <= 1'b0;
    end else begin
      if ((is_po && bank_open) || ((is_cr || is_cw) && !bank_open)) err_closed_reg <= 1'b1;
      if (rd_overlap || wr_overlap) err_overlap_reg <= 1'b1;
    end
  end

  // The read engine fires one cycle early because the storage read is registered.
  diram_burst_ctrl #(.LAT(RD_LAT - 1), .BURST(BURST), .IDX_W(MEM_AW)) u_rd (
    .clk      (clk),
    .rst_n    (reset_poweron_n),
    .req      (is_cr && bank_open),
    .req_idx  (cmd_idx),
    .overlap  (rd_overlap),
    .beat_act (rd_act),
    .beat_idx (rd_idx),
    .beat_num (rd_beat)
  );

  diram_burst_ctrl #(.LAT(WR_LAT), .BURST(BURST), .IDX_W(MEM_AW)) u_wr (
    .clk      (clk),
    .rst_n    (reset_poweron_n),
    .req      (is_cw && bank_open),
    .req_idx  (cmd_idx),
    .overlap  (wr_overlap),
    .beat_act (wr_act),
    .beat_idx (wr_idx),
    .beat_num (wr_beat)
  );

  assign rd_addr = {rd_idx, rd_beat};
  assign wr_addr = {wr_idx, wr_beat};
  assign wr_en   = wr_act && reset_poweron_n;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= dfi__phy__data;
    if (rd_act) rd_mem_reg <= (wr_en && (wr_addr == rd_addr)) ? dfi__phy__data : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      hold_reg     <= '0;
    end else begin
      rd_valid_reg <= rd_act;
      rd_addr_reg  <= rd_addr;
      if (rd_valid_reg) hold_reg <= phy__dfi__data;
    end
  end

  // A write beat landing on the beat being driven this cycle is forwarded so the
  // read reflects every write up to and including the current cycle.
  assign byp = rd_valid_reg && wr_en && (wr_addr == rd_addr_reg);

  assign phy__dfi__valid  = rd_valid_reg;
  assign phy__dfi__data   = !rd_valid_reg ? hold_reg : (byp ? dfi__phy__data : rd_mem_reg);
  assign phy__err_closed  = err_closed_reg;
  assign phy__err_overlap = err_overlap_reg;

endmodule

// File: tb/tb_diram_phy_responder.sv
// Directed bench for diram_phy_responder: a cycle-scheduled behavioural model checked
// every cycle, plus hand-computed literal checks for each scenario.
module tb_diram_phy_responder;

  localparam int BURST  = 2;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 1;
  localparam logic [1:0] PO = 2'b00, PC = 2'b01, CR = 2'b10, CW = 2'b11;
  localparam logic [255:0] A1 = {8{32'hA100_0001}};
  localparam logic [255:0] A2 = {8{32'hA200_0002}};
  localparam logic [255:0] D1 = {8{32'hD100_0011}};
  localparam logic [255:0] D2 = {8{32'hD200_0022}};
  localparam logic [255:0] C1 = {8{32'hC100_0031}};
  localparam logic [255:0] C2 = {8{32'hC200_0032}};
  localparam logic [255:0] B1 = {8{32'hB100_0041}};
  localparam logic [255:0] B2 = {8{32'hB200_0042}};

  logic         clk = 1'b0;
  logic         reset_poweron_n = 1'b0;
  logic         dfi__phy__cs = 1'b0, dfi__phy__cmd1 = 1'b0, dfi__phy__cmd0 = 1'b0;
  logic [4:0]   dfi__phy__bank = '0;
  logic [9:0]   dfi__phy__addr = '0;
  logic [255:0] dfi__phy__data = '0;
  logic         phy__dfi__valid;
  logic [255:0] phy__dfi__data;
  logic         phy__err_closed, phy__err_overlap;

  diram_phy_responder dut (
    .clk              (clk),
    .reset_poweron_n  (reset_poweron_n),
    .dfi__phy__cs     (dfi__phy__cs),
    .dfi__phy__cmd1   (dfi__phy__cmd1),
    .dfi__phy__cmd0   (dfi__phy__cmd0),
    .dfi__phy__bank   (dfi__phy__bank),
    .dfi__phy__addr   (dfi__phy__addr),
    .dfi__phy__data   (dfi__phy__data),
    .phy__dfi__valid  (phy__dfi__valid),
    .phy__dfi__data   (phy__dfi__data),
    .phy__err_closed  (phy__err_closed),
    .phy__err_overlap (phy__err_overlap)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  bit en = 1'b0;

  // Model state: cycle-indexed schedules of expected read/write beats.
  bit           open_m [32];
  bit           errc_m = 1'b0, erro_m = 1'b0;
  int           last_rd = -100, last_wr = -100;
  int           rd_sched [int];
  int           wr_sched [int];
  logic [255:0] mem_m [int];
  logic [255:0] last_data = '0;
  bit           last_known = 1'b1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int b, a, idx;
    logic exp_v;
    if (wr_sched.exists(cyc) && reset_poweron_n) mem_m[wr_sched[cyc]] = dfi__phy__data;
    exp_v = rd_sched.exists(cyc);
    if (exp_v) begin
      if (mem_m.exists(rd_sched[cyc])) begin
        last_data  = mem_m[rd_sched[cyc]];
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end
    chk("m_valid", {255'd0, phy__dfi__valid}, {255'd0, exp_v});
    if (last_known) chk("m_data", phy__dfi__data, last_data);
    chk("m_err_closed", {255'd0, phy__err_closed}, {255'd0, errc_m});
    chk("m_err_overlap", {255'd0, phy__err_overlap}, {255'd0, erro_m});
    if (!reset_poweron_n) begin
      foreach (open_m[i]) open_m[i] = 1'b0;
      errc_m = 1'b0; erro_m = 1'b0;
      last_rd = -100; last_wr = -100;
      rd_sched.delete(); wr_sched.delete();
      last_data = '0; last_known = 1'b1;
    end else if (dfi__phy__cs) begin
      b   = int'(dfi__phy__bank);
      a   = int'(dfi__phy__addr);
      idx = (b * 1024 + a) % 256;
      case ({dfi__phy__cmd1, dfi__phy__cmd0})
        PO: begin if (open_m[b]) errc_m = 1'b1; open_m[b] = 1'b1; end
        PC: open_m[b] = 1'b0;
        CR: if (!open_m[b]) errc_m = 1'b1;
            else if (cyc - last_rd < BURST) erro_m = 1'b1;
            else begin
              last_rd = cyc;
              for (int k = 0; k < BURST; k++) rd_sched[cyc + RD_LAT + k] = idx * BURST + k;
            end
        default: if (!open_m[b]) errc_m = 1'b1;
            else if (cyc - last_wr < BURST) erro_m = 1'b1;
            else begin
              last_wr = cyc;
              for (int k = 0; k < BURST; k++) wr_sched[cyc + WR_LAT + k] = idx * BURST + k;
            end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (en) model_step();
  end

  task automatic set(input logic c, input logic [1:0] op, input int b, input int a, input logic [255:0] d);
    logic [31:0] bv, av;
    bv = b; av = a;
    dfi__phy__cs = c;
    {dfi__phy__cmd1, dfi__phy__cmd0} = op;
    dfi__phy__bank = bv[4:0];
    dfi__phy__addr = av[9:0];
    dfi__phy__data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [1:0] op, input int b, input int a, input logic [255:0] d);
    set(c, op, b, a, d);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, PO, 0, 0, '0);
  endtask

  task automatic pulse_reset();
    reset_poweron_n = 1'b0;
    idle(1);
    reset_poweron_n = 1'b1;
  endtask

  logic [255:0] exp3 [5];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_poweron_n = 1'b1;
    en = 1'b1;
    #2;
    chk("reset_valid", {255'd0, phy__dfi__valid}, 256'd0);
    chk("reset_data", phy__dfi__data, 256'd0);
    chk("reset_errs", {254'd0, phy__err_closed, phy__err_overlap}, 256'd0);

    // Scenario 1: write then read back through bank 3 column 7
    drive(1'b1, PO, 3, 5, '0);
    drive(1'b1, CW, 3, 7, '0);
    drive(1'b0, PO, 0, 0, A1);
    drive(1'b0, PO, 0, 0, A2);
    drive(1'b1, CR, 3, 7, '0);
    idle(3);
    #2;
    chk("t1_beat0_valid", {255'd0, phy__dfi__valid}, 256'd1);
    chk("t1_beat0_data", phy__dfi__data, A1);
    idle(1);
    #2;
    chk("t1_beat1_data", phy__dfi__data, A2);
    idle(1);
    #2;
    chk("t1_after_valid", {255'd0, phy__dfi__valid}, 256'd0);
    chk("t1_hold_data", phy__dfi__data, A2);
    chk("t1_errs", {254'd0, phy__err_closed, phy__err_overlap}, 256'd0);

    // Scenario 6: redundant PC is legal, double PO is not
    drive(1'b1, PO, 1, 2, '0);
    drive(1'b1, PC, 1, 0, '0);
    drive(1'b1, PC, 1, 0, '0);
    idle(1);
    #2;
    chk("t6_pc_noerr", {255'd0, phy__err_closed}, 256'd0);
    drive(1'b1, PO, 1, 2, '0);
    drive(1'b1, PO, 1, 3, '0);
    #2;
    chk("t6_po_twice", {255'd0, phy__err_closed}, 256'd1);

    pulse_reset();

    // Scenario 2: read to a closed bank, then legal traffic (fills index 4)
    drive(1'b1, CR, 9, 0, '0);
    #2;
    chk("t2_closed", {255'd0, phy__err_closed}, 256'd1);
    drive(1'b1, PO, 9, 1, '0);
    drive(1'b1, CW, 9, 4, '0);
    drive(1'b0, PO, 0, 0, D1);
    drive(1'b0, PO, 0, 0, D2);
    idle(4);
    #2;
    chk("t2_sticky", {255'd0, phy__err_closed}, 256'd1);
    chk("t2_no_overlap", {255'd0, phy__err_overlap}, 256'd0);

    // Scenario 3: b4c7 aliases index 7 (A1/A2), b5c4 aliases index 4 (D1/D2)
    drive(1'b1, PO, 4, 0, '0);
    drive(1'b1, PO, 5, 0, '0);
    drive(1'b1, CR, 4, 7, '0);
    idle(1);
    drive(1'b1, CR, 5, 4, '0);
    drive(1'b1, CR, 4, 7, '0);
    exp3[0] = A1; exp3[1] = A2; exp3[2] = D1; exp3[3] = D2;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_stream_valid", {255'd0, phy__dfi__valid}, 256'd1);
      chk("t3_stream_data", phy__dfi__data, exp3[i]);
      idle(1);
    end
    #2;
    chk("t3_end_valid", {255'd0, phy__dfi__valid}, 256'd0);
    chk("t3_overlap", {255'd0, phy__err_overlap}, 256'd1);

    // Scenario 4: read beats coincide with fresh write beats at index 9
    drive(1'b1, PO, 3, 0, '0);
    drive(1'b1, CW, 3, 9, '0);
    drive(1'b0, PO, 0, 0, C1);
    drive(1'b0, PO, 0, 0, C2);
    idle(2);
    drive(1'b1, CR, 3, 9, '0);
    idle(2);
    drive(1'b1, CW, 3, 9, '0);
    set(1'b0, PO, 0, 0, B1);
    #2;
    chk("t4_rdw_beat0", phy__dfi__data, B1);
    step();
    set(1'b0, PO, 0, 0, B2);
    #2;
    chk("t4_rdw_beat1", phy__dfi__data, B2);
    step();
    idle(2);

    // Scenario 5: reset between read beats
    drive(1'b1, PO, 6, 0, '0);
    drive(1'b1, CR, 6, 9, '0);
    idle(3);
    reset_poweron_n = 1'b0;
    #2;
    chk("t5_beat0_valid", {255'd0, phy__dfi__valid}, 256'd1);
    chk("t5_beat0_data", phy__dfi__data, B1);
    step();
    reset_poweron_n = 1'b1;
    #2;
    chk("t5_abort_valid", {255'd0, phy__dfi__valid}, 256'd0);
    chk("t5_abort_data", phy__dfi__data, 256'd0);
    chk("t5_errs_clear", {254'd0, phy__err_closed, phy__err_overlap}, 256'd0);
    step();
    drive(1'b1, CR, 6, 9, '0);
    #2;
    chk("t5_closed_after_reset", {255'd0, phy__err_closed}, 256'd1);
    idle(8);

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
